// File: rtl/core_wb_arbiter.sv
// Round-robin Wishbone arbiter: N_M masters onto one slave port, with locked
// grants held for the whole cycle and a per-access ack/err timeout.
module core_wb_arbiter #(
    parameter int unsigned N_M     = 3,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic [N_M-1:0]       m_cyc_i,
    input  logic [N_M-1:0]       m_stb_i,
    input  logic [N_M-1:0]       m_we_i,
    input  logic [4*N_M-1:0]     m_sel_i,
    input  logic [32*N_M-1:0]    m_adr_i,
    input  logic [32*N_M-1:0]    m_dat_i,
    output logic [31:0]          m_dat_o,
    output logic [N_M-1:0]       m_ack_o,
    output logic [N_M-1:0]       m_err_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [3:0]           s_sel_o,
    output logic [31:0]          s_adr_o,
    output logic [31:0]          s_dat_o,
    input  logic [31:0]          s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    output logic [N_M-1:0]       gnt_o,
    output logic                 timeout_o
);

    localparam int unsigned IDX_W = (N_M > 1) ? $clog2(N_M) : 1;
    localparam int unsigned CNT_W = 16;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_M - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_M-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic               sel_cyc, sel_stb, sel_we;
    logic [3:0]         sel_sel;
    logic [31:0]        sel_adr, sel_dat;
    logic               busy;
    logic               waiting;
    logic               to_hit;

    // Round-robin search starting one past the last granted master.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int unsigned k = 1; k <= N_M; k++) begin
            for (int unsigned j = 0; j < N_M; j++) begin
                if (!pick_vld && m_cyc_i[j] && (j == (32'(last_q) + k) % N_M)) begin
                    pick_vld = 1'b1;
                    pick_idx = IDX_W'(j);
                end
            end
        end
    end

    // One-hot AND-OR mux of the granted master's bus signals.
    always_comb begin
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        sel_we  = 1'b0;
        sel_sel = '0;
        sel_adr = '0;
        sel_dat = '0;
        for (int i = 0; i < int'(N_M); i++) begin
            sel_cyc = sel_cyc | (m_cyc_i[i] & gnt_q[i]);
            sel_stb = sel_stb | (m_stb_i[i] & gnt_q[i]);
            sel_we  = sel_we  | (m_we_i[i]  & gnt_q[i]);
            sel_sel = sel_sel | (m_sel_i[4*i +: 4]   & {4{gnt_q[i]}});
            sel_adr = sel_adr | (m_adr_i[32*i +: 32] & {32{gnt_q[i]}});
            sel_dat = sel_dat | (m_dat_i[32*i +: 32] & {32{gnt_q[i]}});
        end
    end

    assign busy    = (state_q == BUSY) && !rst_i;
    assign waiting = (state_q == BUSY) && sel_stb && !s_ack_i && !s_err_i;
    assign to_hit  = waiting && (cnt_q == CNT_LAST);

    // Next-state logic: grant in IDLE, hold while cyc high, abort on timeout.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = BUSY;
                    gnt_d   = N_M'(1) << pick_idx;
                    last_d  = pick_idx;
                end
            end
            BUSY: begin
                if (!sel_cyc) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (to_hit) begin
                    state_d = DRAIN;
                end else if (waiting) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (!sel_cyc) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slave side follows the granted master; a timeout cuts cyc/stb at once.
    assign s_cyc_o   = busy & sel_cyc & ~to_hit;
    assign s_stb_o   = busy & sel_stb & ~to_hit;
    assign s_we_o    = busy & sel_we;
    assign s_sel_o   = sel_sel;
    assign s_adr_o   = sel_adr;
    assign s_dat_o   = sel_dat;

    assign m_dat_o   = s_dat_i;
    assign m_ack_o   = busy ? (gnt_q & {N_M{s_ack_i}}) : '0;
    assign m_err_o   = busy ? (gnt_q & {N_M{s_err_i | to_hit}}) : '0;
    assign timeout_o = busy & to_hit;
    assign gnt_o     = gnt_q;

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Scoreboarded bench for core_wb_arbiter: grant rotation, locked bursts,
// timeout/drain, ack-beats-timeout and mid-burst reset.
module tb_core_wb_arbiter;

    localparam int unsigned N_M = 3;

    typedef struct packed {
        logic [2:0]  ack;
        logic [2:0]  err;
        logic        to;
        logic [31:0] dat;
    } rsp_t;

    logic           clk;
    logic           rst_i;
    logic [2:0]     m_cyc_i, m_stb_i, m_we_i;
    logic [11:0]    m_sel_i;
    logic [95:0]    m_adr_i, m_dat_i;
    logic [31:0]    m_dat_o;
    logic [2:0]     m_ack_o, m_err_o;
    logic           s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]     s_sel_o;
    logic [31:0]    s_adr_o, s_dat_o;
    logic [31:0]    s_dat_i;
    logic           s_ack_i, s_err_i;
    logic [2:0]     gnt_o;
    logic           timeout_o;

    int   n_checks;
    int   n_errors;
    rsp_t sb_q[$];

    core_wb_arbiter #(.N_M(N_M), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst_i     (rst_i),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_sel_i   (m_sel_i),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_sel_o   (s_sel_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .gnt_o     (gnt_o),
        .timeout_o (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rsp(input logic [2:0] ack, input logic [2:0] err, input logic to,
                            input logic [31:0] dat);
        rsp_t r;
        r.ack = ack;
        r.err = err;
        r.to  = to;
        r.dat = dat;
        sb_q.push_back(r);
    endtask

    // Any ack/err/timeout from the DUT must match the next expected response.
    always @(negedge clk) begin
        if (m_ack_o != 3'b000 || m_err_o != 3'b000 || timeout_o) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", 64'({m_ack_o, m_err_o, timeout_o}), 64'd0);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                check("sb_ack", 64'(m_ack_o), 64'(e.ack));
                check("sb_err", 64'(m_err_o), 64'(e.err));
                check("sb_timeout", 64'(timeout_o), 64'(e.to));
                check("sb_dat", 64'(m_dat_o), 64'(e.dat));
            end
        end
    end

    // Granted master drops cyc; expect same-cycle s_cyc drop, idle gap, new grant.
    task automatic grant_pass(input logic [2:0] new_cyc, input logic [2:0] exp_gnt);
        tick();
        m_cyc_i = new_cyc;
        @(negedge clk);
        check("cyc_drop_same_cycle", 64'(s_cyc_o), 64'd0);
        tick();
        @(negedge clk);
        check("idle_gnt_clear", 64'(gnt_o), 64'd0);
        tick();
        @(negedge clk);
        check("rr_gnt", 64'(gnt_o), 64'(exp_gnt));
        check("rr_s_cyc", 64'(s_cyc_o), 64'd1);
    endtask

    initial begin
        logic [31:0] d;
        n_checks = 0;
        n_errors = 0;
        rst_i    = 1'b1;
        m_cyc_i  = 3'b111;
        m_stb_i  = '0;
        m_we_i   = '0;
        m_sel_i  = '0;
        m_adr_i  = '0;
        m_dat_i  = '0;
        s_dat_i  = '0;
        s_ack_i  = 1'b1;
        s_err_i  = 1'b0;

        // Reset held with requests and a stray ack present.
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("rst_gnt", 64'(gnt_o), 64'd0);
            check("rst_s_cyc", 64'(s_cyc_o), 64'd0);
            check("rst_s_stb", 64'(s_stb_o), 64'd0);
        end

        // Round-robin rotation with all masters requesting.
        tick();
        rst_i   = 1'b0;
        s_ack_i = 1'b0;
        @(negedge clk);
        check("gnt_latency_idle", 64'(gnt_o), 64'd0);
        tick();
        @(negedge clk);
        check("first_gnt", 64'(gnt_o), 64'b001);
        check("first_s_cyc", 64'(s_cyc_o), 64'd1);
        grant_pass(3'b110, 3'b010);
        grant_pass(3'b101, 3'b100);
        grant_pass(3'b011, 3'b001);
        tick();
        m_cyc_i = 3'b000;
        tick();

        // Master 1 locked burst of 4 reads, master 0 requesting throughout.
        m_cyc_i = 3'b011;
        m_stb_i = 3'b010;
        m_adr_i[63:32] = 32'h0000_1000;
        tick();
        for (int b = 0; b < 4; b++) begin
            m_adr_i[63:32] = 32'h0000_1000 + 32'(4 * b);
            s_ack_i = 1'b0;
            @(negedge clk);
            check("burst_gnt_wait", 64'(gnt_o), 64'b010);
            check("burst_adr", 64'(s_adr_o), 64'(32'h0000_1000 + 32'(4 * b)));
            tick();
            d = $urandom;
            s_dat_i = d;
            s_ack_i = 1'b1;
            push_rsp(3'b010, 3'b000, 1'b0, d);
            @(negedge clk);
            check("burst_gnt_ack", 64'(gnt_o), 64'b010);
            tick();
        end
        s_ack_i = 1'b0;
        m_cyc_i = 3'b001;
        m_stb_i = 3'b000;
        @(negedge clk);
        check("burst_end_s_cyc", 64'(s_cyc_o), 64'd0);
        tick();
        tick();
        @(negedge clk);
        check("after_burst_gnt", 64'(gnt_o), 64'b001);
        m_cyc_i = 3'b000;
        tick();
        tick();

        // Master 2 strobes, slave silent: timeout on 8th waiting cycle, then DRAIN.
        m_cyc_i = 3'b100;
        m_stb_i = 3'b100;
        m_adr_i[95:64] = 32'h0000_2000;
        s_dat_i = 32'h0;
        tick();
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) push_rsp(3'b000, 3'b100, 1'b1, 32'h0);
            @(negedge clk);
            check("to_s_cyc", 64'(s_cyc_o), (k < 8) ? 64'd1 : 64'd0);
            tick();
        end
        s_ack_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("drain_s_cyc", 64'(s_cyc_o), 64'd0);
            check("drain_gnt", 64'(gnt_o), 64'b100);
            tick();
        end
        s_ack_i = 1'b0;
        m_cyc_i = 3'b000;
        m_stb_i = 3'b000;
        @(negedge clk);
        check("drain_hold_gnt", 64'(gnt_o), 64'b100);
        tick();
        @(negedge clk);
        check("drain_exit_gnt", 64'(gnt_o), 64'd0);
        tick();

        // Ack on exactly the 8th waiting cycle beats the timeout; write passthrough.
        m_cyc_i = 3'b100;
        m_stb_i = 3'b100;
        m_we_i  = 3'b100;
        m_sel_i[11:8]  = 4'b0011;
        m_dat_i[95:64] = 32'hDEAD_BEEF;
        tick();
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) begin
                s_dat_i = 32'hA5A5_0039;
                s_ack_i = 1'b1;
                push_rsp(3'b100, 3'b000, 1'b0, 32'hA5A5_0039);
            end
            @(negedge clk);
            if (k == 1) begin
                check("wr_s_we", 64'(s_we_o), 64'd1);
                check("wr_s_sel", 64'(s_sel_o), 64'b0011);
                check("wr_s_dat", 64'(s_dat_o), 64'hDEAD_BEEF);
            end
            check("ack_race_s_cyc", 64'(s_cyc_o), 64'd1);
            tick();
        end
        s_ack_i = 1'b0;
        @(negedge clk);
        check("ack_race_stay_busy", 64'(gnt_o), 64'b100);
        check("ack_race_s_cyc_after", 64'(s_cyc_o), 64'd1);
        tick();
        s_err_i = 1'b1;
        s_dat_i = 32'h0000_0E22;
        push_rsp(3'b000, 3'b100, 1'b0, 32'h0000_0E22);
        tick();
        s_err_i = 1'b0;
        m_cyc_i = 3'b000;
        m_stb_i = 3'b000;
        m_we_i  = 3'b000;
        tick();
        tick();

        // Reset mid-burst of master 1, then re-arbitrate from master 0.
        m_cyc_i = 3'b010;
        m_stb_i = 3'b010;
        tick();
        d = 32'h1234_5678;
        s_dat_i = d;
        s_ack_i = 1'b1;
        push_rsp(3'b010, 3'b000, 1'b0, d);
        @(negedge clk);
        check("pre_rst_gnt", 64'(gnt_o), 64'b010);
        tick();
        rst_i = 1'b1;
        tick();
        @(negedge clk);
        check("mid_rst_gnt", 64'(gnt_o), 64'd0);
        check("mid_rst_s_cyc", 64'(s_cyc_o), 64'd0);
        check("mid_rst_ack", 64'(m_ack_o), 64'd0);
        tick();
        rst_i   = 1'b0;
        s_ack_i = 1'b0;
        m_cyc_i = 3'b011;
        m_stb_i = 3'b000;
        tick();
        @(negedge clk);
        check("post_rst_gnt", 64'(gnt_o), 64'b001);
        m_cyc_i = 3'b000;
        tick();
        tick();

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
